cpu_mem_arbiter: RTL and testbench

Shares one single-port unified memory between the cpu instruction-fetch port and the load/store data port. Uses a request/response handshake on each requester side and a req/ack handshake, with variable latency, toward memory. Data accesses have priority. A streak limiter prevents fetch starvation. Sits between the cpu core and the memory model inside the cpu top level.

---
 rtl/cpu_mem_arbiter.sv | 153 +++++++++++++++
 tb/tb_cpu_mem_arbiter.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_mem_arbiter.sv
// Shares one single-port memory between fetch and load/store; data wins until fetch is passed over STARVE_LIMIT times.
// Registered outputs: mem_req one edge after grant, rsp pulse one edge after mem_ack; one transaction in flight.
module cpu_mem_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                i_req,
    input  logic [ADDR_W-1:0]   i_addr,
    output logic                i_rsp_valid,
    output logic [DATA_W-1:0]   i_rdata,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [DATA_W/8-1:0] d_be,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    output logic                d_rsp_valid,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                mem_req,
    output logic                mem_we,
    output logic [DATA_W/8-1:0] mem_be,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic                mem_ack,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                busy
);
    localparam int CNT_W = 4;
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [CNT_W-1:0]    r_streak;
    logic [CNT_W-1:0]    w_streak_nxt;
    logic                w_i_elig;
    logic                w_d_elig;
    logic                w_grant_i;
    logic                w_grant_d;
    logic                w_done;

    logic                r_mem_req;
    logic                r_mem_we;
    logic [DATA_W/8-1:0] r_mem_be;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [DATA_W-1:0]   r_mem_wdata;
    logic                r_i_rsp_valid;
    logic [DATA_W-1:0]   r_i_rdata;
    logic                r_d_rsp_valid;
    logic [DATA_W-1:0]   r_d_rdata;
    logic                r_busy;

    // A requester still seeing its response pulse is holding the old request; skip it.
    assign w_i_elig = i_req && !r_i_rsp_valid;
    assign w_d_elig = d_req && !r_d_rsp_valid;
    assign w_done   = (r_state != IDLE) && mem_ack;

    always_comb begin
        w_state_nxt  = r_state;
        w_streak_nxt = r_streak;
        w_grant_i    = 1'b0;
        w_grant_d    = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_d_elig && (!w_i_elig || (r_streak < LIMIT))) begin
                    w_grant_d   = 1'b1;
                    w_state_nxt = BUSY_D;
                    if (!i_req)
                        w_streak_nxt = '0;
                    else if (r_streak < LIMIT)
                        w_streak_nxt = r_streak + CNT_W'(1);
                end else if (w_i_elig) begin
                    w_grant_i    = 1'b1;
                    w_state_nxt  = BUSY_I;
                    w_streak_nxt = '0;
                end
            end
            BUSY_I, BUSY_D: begin
                if (mem_ack)
                    w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= IDLE;
            r_streak <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_streak <= w_streak_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_mem_req     <= 1'b0;
            r_mem_we      <= 1'b0;
            r_mem_be      <= '0;
            r_mem_addr    <= '0;
            r_mem_wdata   <= '0;
            r_i_rsp_valid <= 1'b0;
            r_i_rdata     <= '0;
            r_d_rsp_valid <= 1'b0;
            r_d_rdata     <= '0;
            r_busy        <= 1'b0;
        end else begin
            r_i_rsp_valid <= 1'b0;
            r_d_rsp_valid <= 1'b0;
            if (w_grant_d) begin
                r_mem_req   <= 1'b1;
                r_mem_we    <= d_we;
                r_mem_be    <= d_be;
                r_mem_addr  <= d_addr;
                r_mem_wdata <= d_wdata;
                r_busy      <= 1'b1;
            end else if (w_grant_i) begin
                r_mem_req   <= 1'b1;
                r_mem_we    <= 1'b0;
                r_mem_be    <= '1;
                r_mem_addr  <= i_addr;
                r_mem_wdata <= '0;
                r_busy      <= 1'b1;
            end else if (w_done) begin
                r_mem_req <= 1'b0;
                r_busy    <= 1'b0;
                if (r_state == BUSY_I) begin
                    r_i_rsp_valid <= 1'b1;
                    r_i_rdata     <= mem_rdata;
                end else begin
                    r_d_rsp_valid <= 1'b1;
                    if (!r_mem_we)
                        r_d_rdata <= mem_rdata;
                end
            end
        end
    end

    assign mem_req     = r_mem_req;
    assign mem_we      = r_mem_we;
    assign mem_be      = r_mem_be;
    assign mem_addr    = r_mem_addr;
    assign mem_wdata   = r_mem_wdata;
    assign i_rsp_valid = r_i_rsp_valid;
    assign i_rdata     = r_i_rdata;
    assign d_rsp_valid = r_d_rsp_valid;
    assign d_rdata     = r_d_rdata;
    assign busy        = r_busy;
endmodule

// File: tb/tb_cpu_mem_arbiter.sv
`timescale 1ns/1ps
// Bench for cpu_mem_arbiter: directed vector table, streak and back-to-back sequences, random traffic vs a model.
module tb_cpu_mem_arbiter;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int BW  = DW/8;
    localparam int LIM = 4;
    localparam int NV  = 19;

    typedef struct packed {
        logic          rst;
        logic          ir;
        logic [AW-1:0] ia;
        logic          dr;
        logic          dwe;
        logic [BW-1:0] dbe;
        logic [AW-1:0] da;
        logic [DW-1:0] dwd;
        logic          ack;
        logic [DW-1:0] mrd;
    } in_t;

    typedef struct packed {
        logic          mreq;
        logic          mwe;
        logic [BW-1:0] mbe;
        logic [AW-1:0] maddr;
        logic [DW-1:0] mwd;
        logic          irv;
        logic [DW-1:0] ird;
        logic          drv;
        logic [DW-1:0] drd;
    } out_t;

    typedef struct packed {
        in_t  i;
        out_t o;
    } vec_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          i_req, i_rsp_valid;
    logic [AW-1:0] i_addr;
    logic [DW-1:0] i_rdata;
    logic          d_req, d_we, d_rsp_valid;
    logic [BW-1:0] d_be;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata, d_rdata;
    logic          mem_req, mem_we, mem_ack, busy;
    logic [BW-1:0] mem_be;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;

    always #5 clk = ~clk;

    cpu_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(LIM)) dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_rsp_valid(i_rsp_valid), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rsp_valid(d_rsp_valid), .d_rdata(d_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata), .busy(busy)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input in_t x);
        reset     = x.rst;
        i_req     = x.ir;
        i_addr    = x.ia;
        d_req     = x.dr;
        d_we      = x.dwe;
        d_be      = x.dbe;
        d_addr    = x.da;
        d_wdata   = x.dwd;
        mem_ack   = x.ack;
        mem_rdata = x.mrd;
    endtask

    task automatic compare(input string tag, input out_t e, input bit full);
        check({tag, " mem_req"}, 32'(mem_req), 32'(e.mreq));
        check({tag, " busy"}, 32'(busy), 32'(e.mreq));
        check({tag, " i_rsp_valid"}, 32'(i_rsp_valid), 32'(e.irv));
        check({tag, " d_rsp_valid"}, 32'(d_rsp_valid), 32'(e.drv));
        check({tag, " d_rdata"}, d_rdata, e.drd);
        if (e.mreq || full) begin
            check({tag, " mem_we"}, 32'(mem_we), 32'(e.mwe));
            check({tag, " mem_be"}, 32'(mem_be), 32'(e.mbe));
            check({tag, " mem_addr"}, mem_addr, e.maddr);
            check({tag, " mem_wdata"}, mem_wdata, e.mwd);
        end
        if (e.irv || full)
            check({tag, " i_rdata"}, i_rdata, e.ird);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        vec_t          v [NV];
        bit            exp_d [10];
        int            ngr, nrsp;
        bit            prev, adv, wi, wd, i_after, d_after;
        logic [AW-1:0] cur_addr;
        in_t           cur;
        out_t          o, n;
        int            own, strk;

        // reset, ack under reset, single fetch, store then load, reset mid-store, late/spurious acks
        v[0]  = '{'{1,0,0,0,0,0,0,0,0,0}, '{0,0,0,0,0,0,0,0,0}};
        v[1]  = '{'{1,0,0,0,0,0,0,0,1,32'hFFFF}, '{0,0,0,0,0,0,0,0,0}};
        v[2]  = '{'{0,1,32'h100,0,0,0,0,0,0,0}, '{1,0,4'hF,32'h100,0,0,0,0,0}};
        v[3]  = '{'{0,1,32'h100,0,0,0,0,0,0,0}, '{1,0,4'hF,32'h100,0,0,0,0,0}};
        v[4]  = '{'{0,1,32'h100,0,0,0,0,0,1,32'h00500093}, '{0,0,0,0,0,1,32'h00500093,0,0}};
        v[5]  = '{'{0,1,32'h100,0,0,0,0,0,0,0}, '{0,0,0,0,0,0,0,0,0}};
        v[6]  = '{'{0,0,0,0,0,0,0,0,0,0}, '{0,0,0,0,0,0,0,0,0}};
        v[7]  = '{'{0,0,0,1,1,4'h3,32'h200,32'hDEADBEEF,0,0}, '{1,1,4'h3,32'h200,32'hDEADBEEF,0,0,0,0}};
        v[8]  = '{'{0,0,0,1,1,4'h3,32'h200,32'hDEADBEEF,1,32'h12345678}, '{0,0,0,0,0,0,0,1,0}};
        v[9]  = '{'{0,0,0,1,1,4'h3,32'h200,32'hDEADBEEF,0,0}, '{0,0,0,0,0,0,0,0,0}};
        v[10] = '{'{0,0,0,1,0,4'hF,32'h200,0,0,0}, '{1,0,4'hF,32'h200,0,0,0,0,0}};
        v[11] = '{'{0,0,0,1,0,4'hF,32'h200,0,1,32'h0000BEEF}, '{0,0,0,0,0,0,0,1,32'hBEEF}};
        v[12] = '{'{0,0,0,1,0,4'hF,32'h200,0,0,0}, '{0,0,0,0,0,0,0,0,32'hBEEF}};
        v[13] = '{'{0,0,0,1,1,4'hF,32'h300,32'hCAFEF00D,0,0}, '{1,1,4'hF,32'h300,32'hCAFEF00D,0,0,0,32'hBEEF}};
        v[14] = '{'{0,0,0,1,1,4'hF,32'h300,32'hCAFEF00D,0,0}, '{1,1,4'hF,32'h300,32'hCAFEF00D,0,0,0,32'hBEEF}};
        v[15] = '{'{1,0,0,1,1,4'hF,32'h300,32'hCAFEF00D,0,0}, '{0,0,0,0,0,0,0,0,0}};
        v[16] = '{'{0,0,0,0,0,0,0,0,1,32'hAAAA}, '{0,0,0,0,0,0,0,0,0}};
        v[17] = '{'{0,0,0,0,0,0,0,0,1,32'h5555}, '{0,0,0,0,0,0,0,0,0}};
        v[18] = '{'{0,0,0,0,0,0,0,0,1,32'h5555}, '{0,0,0,0,0,0,0,0,0}};

        drive(v[0].i);
        #1;
        for (int k = 0; k < NV; k++) begin
            drive(v[k].i);
            tick();
            compare($sformatf("vec%0d", k), v[k].o, v[k].i.rst);
        end

        // Streak limit: d held, i withdrawn only while d's response is showing.
        exp_d = '{1,1,1,1,0,1,1,1,1,0};
        drive('{1,0,0,0,0,0,0,0,0,0});
        tick();
        reset = 0; d_req = 1; d_we = 0; d_be = '1; d_addr = 32'h500; d_wdata = 0;
        i_req = 1; i_addr = 32'h400;
        ngr = 0; prev = 0;
        for (int c = 0; c < 200 && ngr < 10; c++) begin
            tick();
            if (mem_req && !prev) begin
                check($sformatf("streak_order%0d", ngr), 32'(mem_addr == 32'h500), 32'(exp_d[ngr]));
                ngr++;
            end
            prev      = mem_req;
            mem_ack   = mem_req;
            mem_rdata = 32'h0;
            i_req     = !d_rsp_valid;
        end
        check("streak_grants", 32'(ngr), 32'd10);

        // Back-to-back fetches, request held through each response pulse.
        drive('{1,0,0,0,0,0,0,0,0,0});
        tick();
        reset = 0; i_req = 1; cur_addr = 32'h1000; i_addr = cur_addr;
        ngr = 0; nrsp = 0; adv = 0; prev = 0;
        for (int c = 0; c < 200 && nrsp < 6; c++) begin
            tick();
            if (mem_req && !prev) begin
                check("b2b_addr", mem_addr, cur_addr);
                check("b2b_one_per_rsp", 32'(ngr), 32'(nrsp));
                ngr++;
            end
            prev = mem_req;
            if (i_rsp_valid) begin
                check("b2b_rdata", i_rdata, cur_addr ^ 32'h5A5A_0000);
                nrsp++;
            end
            mem_ack   = mem_req;
            mem_rdata = mem_addr ^ 32'h5A5A_0000;
            if (adv) begin
                cur_addr = cur_addr + 4;
                i_addr   = cur_addr;
                adv      = 0;
            end
            if (i_rsp_valid) adv = 1;
        end
        check("b2b_rsp_count", 32'(nrsp), 32'd6);

        // Random protocol-respecting traffic against a transaction-level model.
        cur = '0; o = '0; own = 0; strk = 0; i_after = 0; d_after = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            cur.rst = (cyc < 2) || ($urandom_range(0, 79) == 0);
            if (o.irv) i_after = 1;
            else if (i_after) begin
                i_after = 0;
                cur.ir  = 1'($urandom_range(0, 1));
                cur.ia  = $urandom;
            end else if (!cur.ir) begin
                cur.ir = ($urandom_range(0, 2) == 0);
                cur.ia = $urandom;
            end
            if (o.drv) d_after = 1;
            else if (d_after || !cur.dr) begin
                cur.dr  = d_after ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 2) == 0);
                d_after = 0;
                cur.dwe = 1'($urandom_range(0, 1));
                cur.dbe = 4'($urandom_range(0, 15));
                cur.da  = $urandom;
                cur.dwd = $urandom;
            end
            cur.ack = ($urandom_range(0, 2) == 0);
            cur.mrd = $urandom;

            n = o; n.irv = 0; n.drv = 0;
            if (cur.rst) begin
                n = '0; own = 0; strk = 0;
            end else if (own == 0) begin
                wi = cur.ir && !o.irv;
                wd = cur.dr && !o.drv;
                if (wd && (!wi || strk < LIM)) begin
                    own = 2; n.mreq = 1; n.mwe = cur.dwe; n.mbe = cur.dbe; n.maddr = cur.da; n.mwd = cur.dwd;
                    strk = cur.ir ? ((strk + 1 > LIM) ? LIM : strk + 1) : 0;
                end else if (wi) begin
                    own = 1; n.mreq = 1; n.mwe = 0; n.mbe = '1; n.maddr = cur.ia; n.mwd = 0;
                    strk = 0;
                end
            end else if (cur.ack) begin
                n.mreq = 0;
                if (own == 1) begin
                    n.irv = 1; n.ird = cur.mrd;
                end else begin
                    n.drv = 1;
                    if (!o.mwe) n.drd = cur.mrd;
                end
                own = 0;
            end

            drive(cur);
            tick();
            compare("rand", n, cur.rst);
            o = n;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
